// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbitration of N_REQ clients onto one UART
// transmitter. A winner's character is latched, launched with tx_send, and
// tracked through the transmitter's busy/idle handshake with a per-phase
// timeout.
module uart_tx_arbiter #(
  parameter  int N_REQ       = 4,
  parameter  int DATA_LENGTH = 8,
  parameter  int TIMEOUT     = 4096,
  localparam int OW          = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int CW          = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1
) (
  input  logic                         tx_clk,
  input  logic                         rst,
  input  logic [N_REQ-1:0]             req,
  input  logic [N_REQ*DATA_LENGTH-1:0] req_data,
  output logic [N_REQ-1:0]             gnt,
  output logic [N_REQ-1:0]             done,
  output logic                         err,
  output logic [OW-1:0]                owner,
  output logic                         busy,
  output logic [DATA_LENGTH-1:0]       tx_datain,
  output logic                         tx_send,
  input  logic                         tx_done
);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE} state_t;

  state_t                 state, state_nxt;
  logic [OW-1:0]          last;
  logic [OW-1:0]          win;
  logic [OW-1:0]          idx;
  logic                   found;
  logic [DATA_LENGTH-1:0] dsel;
  logic [CW-1:0]          cnt;
  logic                   cnt_max;
  logic                   exit_ok;
  logic                   timeout;
  int                     cand;

  // Round-robin search starting one past the last owner, wrapping once.
  always_comb begin
    win   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = int'(last) + 1 + i;
      if (cand >= N_REQ) cand = cand - N_REQ;
      idx = OW'(cand);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // Character slice of the current search winner.
  always_comb begin
    dsel = '0;
    for (int i = 0; i < N_REQ; i++)
      if (OW'(i) == win) dsel = req_data[i*DATA_LENGTH +: DATA_LENGTH];
  end

  assign cnt_max = (cnt == CW'(TIMEOUT - 1));

  // State register; reset aborts any frame in flight.
  always_ff @(posedge tx_clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state plus exit/timeout decode. A phase that reaches the last
  // counter value without its exit condition gives up back to IDLE.
  always_comb begin
    state_nxt = state;
    exit_ok   = 1'b0;
    case (state)
      IDLE: if (found) state_nxt = LAUNCH;
      LAUNCH: begin
        exit_ok = !tx_done;
        if (exit_ok)      state_nxt = WAIT_DONE;
        else if (cnt_max) state_nxt = IDLE;
      end
      WAIT_DONE: begin
        exit_ok = tx_done;
        if (exit_ok || cnt_max) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    timeout = (state != IDLE) && cnt_max && !exit_ok;
  end

  // Completion pulse routed to the current owner only.
  always_comb begin
    done = '0;
    if (state == WAIT_DONE && tx_done) done[owner] = 1'b1;
  end

  assign err     = timeout;
  assign busy    = (state != IDLE);
  assign tx_send = (state == LAUNCH);

  // Grant latch, owner/last tracking and the phase counter.
  always_ff @(posedge tx_clk or posedge rst) begin
    if (rst) begin
      gnt       <= '0;
      owner     <= '0;
      last      <= OW'(N_REQ - 1);
      tx_datain <= '0;
      cnt       <= '0;
    end else begin
      gnt <= '0;
      if (state == IDLE && found) begin
        gnt[win]  <= 1'b1;
        owner     <= win;
        tx_datain <= dsel;
      end
      if ((state == WAIT_DONE && tx_done) || timeout) last <= owner;
      if (state_nxt != state) cnt <= '0;
      else if (state != IDLE) cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: the bench plays the transmitter by
// driving tx_done by hand and checks grants, data, done/err and reset.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int DL = 8;
  localparam int TO = 16;

  logic          tx_clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic [N*DL-1:0] req_data;
  logic [N-1:0]  gnt, done;
  logic          err, busy, tx_send, tx_done;
  logic [1:0]    owner;
  logic [DL-1:0] tx_datain;

  int n_tests = 0;
  int n_fail  = 0;

  uart_tx_arbiter #(.N_REQ(N), .DATA_LENGTH(DL), .TIMEOUT(TO)) dut (
    .tx_clk(tx_clk), .rst(rst), .req(req), .req_data(req_data),
    .gnt(gnt), .done(done), .err(err), .owner(owner), .busy(busy),
    .tx_datain(tx_datain), .tx_send(tx_send), .tx_done(tx_done)
  );

  always #5 tx_clk = ~tx_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge tx_clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    @(posedge tx_clk);
    #1;
    rst = 1'b0;
  endtask

  // One full frame with the current req pattern; w is the expected winner.
  task automatic frame(input int w, input string tag);
    tick;
    chk({tag, " gnt"},   32'(gnt),   32'(1) << w);
    chk({tag, " owner"}, 32'(owner), 32'(w));
    chk({tag, " send"},  32'(tx_send), 32'd1);
    tx_done = 1'b0;
    tick;
    chk({tag, " gnt_off"},  32'(gnt),     32'd0);
    chk({tag, " send_off"}, 32'(tx_send), 32'd0);
    tx_done = 1'b1;
    #1;
    chk({tag, " done"}, 32'(done), 32'(1) << w);
    chk({tag, " err"},  32'(err),  32'd0);
    tick;
    chk({tag, " idle"},    32'(busy), 32'd0);
    chk({tag, " idle_gnt"}, 32'(gnt), 32'd0);
  endtask

  initial begin
    rst = 1'b1; req = '0; req_data = '0; tx_done = 1'b1;
    repeat (2) @(posedge tx_clk);
    #1;
    chk("rst busy",  32'(busy),      32'd0);
    chk("rst send",  32'(tx_send),   32'd0);
    chk("rst owner", 32'(owner),     32'd0);
    chk("rst data",  32'(tx_datain), 32'd0);
    chk("rst pulses", 32'({gnt, done, err}), 32'd0);
    rst = 1'b0;

    // Single requester 2 with A5.
    req = 4'b0100;
    req_data = 32'h11_A5_22_33;
    tick;
    chk("s1 gnt",  32'(gnt),       32'h4);
    chk("s1 data", 32'(tx_datain), 32'hA5);
    chk("s1 send", 32'(tx_send),   32'd1);
    req = '0;
    tick;
    chk("s1 gnt_pulse", 32'(gnt),     32'd0);
    chk("s1 send_hold", 32'(tx_send), 32'd1);
    tx_done = 1'b0;
    tick;
    chk("s1 send_drop", 32'(tx_send), 32'd0);
    chk("s1 no_done",   32'(done),    32'd0);
    tx_done = 1'b1;
    #1;
    chk("s1 done", 32'(done), 32'h4);
    tick;
    chk("s1 idle", 32'(busy), 32'd0);

    // All four requesting: 0,1,2,3,0.
    do_reset;
    req = 4'b1111;
    req_data = 32'h44_33_22_11;
    frame(0, "rr0");
    frame(1, "rr1");
    frame(2, "rr2");
    frame(3, "rr3");
    frame(0, "rr4");

    // After owner 1, requesters 0 and 1 pending: 0 wins, then 1.
    do_reset;
    req = 4'b0010;
    frame(1, "pri1");
    req = 4'b0011;
    frame(0, "pri0");
    frame(1, "pri1b");

    // Winner drops req and changes data after grant.
    req = 4'b0001;
    req_data = 32'h00_00_00_3C;
    tick;
    chk("hold gnt", 32'(gnt), 32'h1);
    req = '0;
    req_data = '1;
    tick;
    chk("hold data1", 32'(tx_datain), 32'h3C);
    tx_done = 1'b0;
    tick;
    chk("hold data2", 32'(tx_datain), 32'h3C);
    tx_done = 1'b1;
    #1;
    chk("hold done", 32'(done), 32'h1);
    chk("hold data3", 32'(tx_datain), 32'h3C);
    tick;

    // Timeout in LAUNCH: tx_done never drops.
    req = 4'b1000;
    tick;
    chk("to gnt", 32'(gnt), 32'h8);
    req = '0;
    for (int i = 1; i < TO - 1; i++) begin
      tick;
      chk("to early_err", 32'(err), 32'd0);
    end
    tick;
    chk("to err",  32'(err),  32'd1);
    chk("to done", 32'(done), 32'd0);
    tick;
    chk("to err_pulse", 32'(err),     32'd0);
    chk("to busy",      32'(busy),    32'd0);
    chk("to send",      32'(tx_send), 32'd0);
    chk("to done2",     32'(done),    32'd0);

    // Reset in the middle of WAIT_DONE.
    req = 4'b0100;
    tick;
    req = '0;
    tx_done = 1'b0;
    tick;
    chk("mr busy_pre", 32'(busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("mr busy",  32'(busy),    32'd0);
    chk("mr send",  32'(tx_send), 32'd0);
    chk("mr owner", 32'(owner),   32'd0);
    tx_done = 1'b1;
    #1;
    chk("mr done", 32'(done), 32'd0);
    @(negedge tx_clk);
    rst = 1'b0;
    req = 4'b0001;
    tick;
    chk("mr gnt", 32'(gnt), 32'h1);
    req = '0;
    tx_done = 1'b0;
    tick;
    tx_done = 1'b1;
    tick;
    chk("mr end", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, giving the number of requesters (legal range 1..8).
REQ-002 SHALL have parameter DATA_LENGTH, default 8, giving the bits per character.
REQ-003 SHALL have parameter TIMEOUT, default 4096, giving the maximum tx_clk cycles per handshake phase (legal minimum 2).
REQ-004 SHALL have port tx_clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  reset; asynchronous and active-high.
REQ-006 SHALL have port req  input  N_REQ  per-requester level request.
REQ-007 SHALL have port req_data  input  N_REQ*DATA_LENGTH  character per requester; requester k uses bits [k*DATA_LENGTH +: DATA_LENGTH].
REQ-008 SHALL have port gnt  output  N_REQ  one-hot, one-cycle pulse marking the winner, asserted on the cycle its data is latched.
REQ-009 SHALL have port done  output  N_REQ  one-hot, one-cycle pulse when the owner's character completes.
REQ-010 SHALL have port err  output  1  one-cycle pulse on a handshake timeout.
REQ-011 SHALL have port owner  output  clog2(N_REQ) (minimum 1)  index of the current or last owner.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.
REQ-013 SHALL have port tx_datain  output  DATA_LENGTH  latched character sent to the transmitter.
REQ-014 SHALL have port tx_send  output  1  launch request to the transmitter.
REQ-015 SHALL have port tx_done  input  1  transmitter status: high when the transmitter is idle, low while a frame is in flight.

Function
REQ-016 SHALL implement a three-state FSM with states IDLE, LAUNCH and WAIT_DONE.
REQ-017 In IDLE, with any req bit high, SHALL select a winner by round-robin, searching from (last+1) mod N_REQ upward with wrap-around, where last is the previous owner (reset value N_REQ-1).
REQ-018 On the selecting edge, SHALL register tx_datain from the winner's req_data slice, set owner to the winner, pulse gnt[winner] for one cycle, and move to LAUNCH.
REQ-019 In LAUNCH, SHALL hold tx_send=1; on the first cycle tx_done is sampled 0, SHALL set tx_send=0 on the next edge and move to WAIT_DONE.
REQ-020 In WAIT_DONE, SHALL hold tx_send=0; when tx_done is sampled 1, SHALL pulse done[owner] for one cycle, update last to owner, and return to IDLE.
REQ-021 SHALL hold tx_datain stable from grant until the FSM returns to IDLE; a req deassertion or req_data change after grant SHALL NOT affect the frame in progress.
REQ-022 SHALL keep a phase counter that clears on entry to LAUNCH and to WAIT_DONE and increments once per cycle while in either state.
REQ-023 When the counter reaches TIMEOUT-1 with the exit condition still unmet, SHALL pulse err, drop tx_send, return to IDLE, update last to owner, and SHALL NOT pulse done.
REQ-024 SHALL spend at least one cycle in IDLE between consecutive grants, so a req that is high on the done cycle is arbitrated on the following edge.
REQ-025 SHALL give a single continuously requesting client back-to-back grants; with several requesters active, each SHALL be served once before any is served twice.
REQ-026 SHALL ignore req bits while busy=1; gnt, done and err SHALL never be asserted on the same cycle as each other.
REQ-027 With N_REQ=1, SHALL always select index 0.

Reset
REQ-028 On rst assertion, SHALL immediately force the FSM to IDLE, with tx_send=0, gnt=0, done=0, err=0, busy=0, owner=0, tx_datain=0, counter=0 and last=N_REQ-1, independent of tx_clk.
REQ-029 SHALL abort any frame in progress on reset mid-operation without pulsing done or err, and SHALL allow arbitration from the first edge after rst deasserts.

Verification
REQ-030 Reset, then req=4'b0100 with slice 2 = 8'hA5 -> gnt=4'b0100 one cycle, tx_datain=8'hA5, tx_send=1 until the bench drops tx_done, done=4'b0100 when tx_done returns to 1.
REQ-031 req=4'b1111 held for four frames after reset -> grant order 0,1,2,3, then 0 again.
REQ-032 After owner 1 completes, req=4'b0011 -> grant goes to 0 next, not 1.
REQ-033 tx_done held at 1 after launch, TIMEOUT=16 -> err pulses 15 cycles after LAUNCH entry, tx_send=0, done never asserted, busy=0 on the next cycle.
REQ-034 rst asserted mid-WAIT_DONE -> tx_send=0 and busy=0 immediately, no done pulse; after release, req=4'b0001 -> gnt=4'b0001.
REQ-035 Winner drops req and changes req_data on the cycle after gnt -> tx_datain is unchanged through done.
